// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bus of the pipelined CLA add/sub unit.
// Handshake: a beat moves on a rising clk edge where valid && ready; the producer holds its payload and valid steady until then, ready may depend combinationally on the downstream side.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, flag_n, flag_z, flag_v
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, flag_n, flag_z, flag_v
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Elastic pipelined carry-lookahead add/sub with optional saturation and N/Z/V flags.
// Each stage resolves NGROUPS/STAGES lookahead groups; the final stage also saturates and registers the flags.
module cla_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  cla_addsub_pipe_if.slave bus
);
  localparam int NGROUPS = WIDTH / GROUP;
  localparam int GPS     = NGROUPS / STAGES;
  localparam int SBITS   = GPS * GROUP;

  // Stage registers: operands, partial sum, carry into the next stage, mode.
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              c_q [STAGES];
  logic [1:0]        m_q [STAGES];
  logic              n_q, z_q, v_q;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic              src_c [STAGES];
  logic [1:0]        src_m [STAGES];
  logic              src_v [STAGES];
  logic [WIDTH-1:0]  s_d   [STAGES];
  logic              c_d   [STAGES];
  logic              en    [STAGES];

  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = bus.mode[0] ? ~bus.b : bus.b;
    src_s[0] = '0;
    src_c[0] = bus.mode[0];
    src_m[0] = bus.mode;
    src_v[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_m[k] = m_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  logic [GROUP-1:0] gv, pv;
  logic             cc, bc, gg, pg;
  int               base;

  always_comb begin
    gv   = '0;
    pv   = '0;
    cc   = 1'b0;
    bc   = 1'b0;
    gg   = 1'b0;
    pg   = 1'b0;
    base = 0;
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = src_s[k];
      cc     = src_c[k];
      for (int gi = 0; gi < GPS; gi++) begin
        base = k * SBITS + gi * GROUP;
        gv   = src_a[k][base +: GROUP] & src_b[k][base +: GROUP];
        pv   = src_a[k][base +: GROUP] ^ src_b[k][base +: GROUP];
        bc   = cc;
        gg   = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
          s_d[k][base + j] = pv[j] ^ bc;
          bc = gv[j] | (pv[j] & bc);
          gg = gv[j] | (pv[j] & gg);
        end
        pg = &pv;
        cc = gg | (pg & cc);
      end
      c_d[k] = cc;
    end
  end

  logic [WIDTH-1:0] raw, fin;
  logic             sa, sb, ovf;

  always_comb begin
    raw = s_d[STAGES-1];
    sa  = src_a[STAGES-1][WIDTH-1];
    sb  = src_b[STAGES-1][WIDTH-1];
    ovf = (sa == sb) && (raw[WIDTH-1] != sa);
    fin = raw;
    if (src_m[STAGES-1][1] && ovf)
      fin = sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  // A stage may load when any register from it to the output still has room, or the output drains.
  logic all_full;
  always_comb begin
    all_full = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      all_full = 1'b1;
      for (int j = k; j < STAGES; j++) all_full = all_full & vld_q[j];
      en[k] = bus.out_ready || !all_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= 2'b00;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            s_q[k] <= (k == STAGES - 1) ? fin : s_d[k];
            c_q[k] <= c_d[k];
            m_q[k] <= src_m[k];
          end
        end
      end
      if (en[STAGES-1] && src_v[STAGES-1]) begin
        n_q <= fin[WIDTH-1];
        z_q <= (fin == '0);
        v_q <= ovf;
      end
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_v    = v_q;
endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined successor to the ALU's 16-bit CLA add/sub datapath.
- Operand width and carry-lookahead group size are generic.
- Carry chain is split across STAGES register stages, with valid/ready elastic handshaking and back-pressure.
- Adds saturating modes and N/Z/V flags. Sits between the ALU operand mux and the writeback/flag register path.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP.
- GROUP, 4, bits per CLA group (group generate/propagate unit).
- STAGES, 2, pipeline register stages; NGROUPS=WIDTH/GROUP must be divisible by STAGES; legal range 1..NGROUPS.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/mode valid
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- mode  in  2  00 add, 01 sub, 10 saturating add, 11 saturating sub
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- flag_n  out  1  sum[WIDTH-1]
- flag_z  out  1  sum==0
- flag_v  out  1  signed overflow of the unsaturated operation

Behaviour:
- Reset: synchronous on rst. All stage valid bits clear. out_valid=0, sum=0, flags=0. in_ready=1 the cycle after reset deasserts.
- Reset mid-operation discards all in-flight operations; nothing is emitted for them.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - sum/flags/out_valid must hold stable while out_valid && !out_ready.
- Sub: B is inverted and carry-in=1 (two's complement), for modes 01 and 11.
- Stage k (0..STAGES-1) processes groups [k*NGROUPS/STAGES .. (k+1)*NGROUPS/STAGES-1].
  - Within a stage: group carries via lookahead, C[i+1]=Gg[i] | (Pg[i] & C[i]).
  - Stage registers hold: computed low sum bits, the carry out of the last group, and the remaining unprocessed operand bits, mode, and sign bits of A and B_in.
- Latency: STAGES cycles from input transfer to out_valid with no back-pressure. Throughput is 1 op/cycle.
- Elastic pipeline:
  - Stage k advances when its successor is empty or advancing.
  - The last stage advances when !out_valid || out_ready.
  - in_ready = !valid[0] || advance[0] (combinational from out_ready through the chain; no bubble on simultaneous push/pop).
- Overflow: V = (signA == signB_in) && (signSum != signA), computed in the final stage.
- Saturation (modes 1x): if V, sum = signA ? {1,0...0} : {0,1...1}; otherwise the raw sum. flag_v still reports the raw overflow.
- Flags derive from the final (possibly saturated) sum, except V. Flags are registered with sum.
- Carry-out is discarded; width wraps modulo 2^WIDTH in modes 0x.
- Full pipeline with out_ready=0: exactly STAGES ops are held, in_ready=0, and no data is lost or duplicated.
- in_valid is ignored while rst=1.

Test Plan:
- WIDTH=16,STAGES=2, a=0x1234,b=0x0FCD,mode=00, out_ready=1 -> out_valid at +2 cycles, sum=0x2201, N=0,Z=0,V=0.
- a=0x7FFF,b=0x0001: mode=00 -> sum=0x8000,N=1,V=1; mode=10 -> sum=0x7FFF,N=0,V=1.
- a=0x8000,b=0x0001,mode=11 -> sum=0x8000,V=1. Same operands, mode=01 -> sum=0x7FFF,V=1. a=0x0005,b=0x0005,mode=01 -> sum=0,Z=1.
- Carry across stage boundary: a=0x00FF,b=0x0001,mode=00 -> sum=0x0100. a=0xFFFF,b=0x0001 -> sum=0x0000,Z=1,V=0.
- Back-pressure:
  - Stream 5 ops, hold out_ready=0 -> in_ready drops after 2 accepted, first result held stable.
  - Release out_ready -> all 5 results emitted in order, one per cycle, with no loss or duplication.
- Reset mid-stream with 2 ops in flight -> out_valid=0 next cycle, no stale result ever emitted, in_ready=1.
- Sweep params (WIDTH=32,GROUP=4,STAGES=4; WIDTH=8,STAGES=1) with 10k random ops versus a reference model (a±b, saturation rule) -> zero mismatches; latency equals STAGES.
